// File: rtl/fpu_types.sv
// Shared FPU types: field widths and the intermediate-writeback payload
// carried from every FP execution unit to the writeback arbiter.
package fpu_types;

  localparam int EXP_WIDTH_SP = 8;
  localparam int EXP_WIDTH_DP = 11;
  // Two extra bits let an unrounded result express over- and underflow.
  localparam int EXP_WIDTH    = EXP_WIDTH_DP + 2;
  localparam int GRS_WIDTH    = 3;
  localparam int ID_WIDTH     = 4;
  localparam int REG_WIDTH    = 5;
  localparam int FFLAGS_WIDTH = 5;
  localparam int CLZ_WIDTH    = 6;
  localparam int SHIFT_WIDTH  = 6;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4,
    RM_DYN = 3'd7
  } rm_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [REG_WIDTH-1:0]    rd;
    logic [FFLAGS_WIDTH-1:0] fflags;
    rm_e                     rm;
    logic [GRS_WIDTH-1:0]    grs;
    logic [CLZ_WIDTH-1:0]    clz;
    logic [SHIFT_WIDTH-1:0]  shift;
    logic [EXP_WIDTH-1:0]    exponent;
  } fp_wb_payload_t;

endpackage

// File: rtl/fp_wb_age_counter.sv
// Per-source wait counter: counts cycles a request sits un-acknowledged,
// saturating at MAX_WAIT, and flags starvation once saturated.
module fp_wb_age_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         ack,
  output logic [$clog2(MAX_WAIT+1)-1:0] count,
  output logic                         starved
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  // NOTE: count_d gets a value on every path so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (!req || ack) begin
      count_d = '0;
    end else if (count_q != WAIT_MAX) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign starved = (count_q == WAIT_MAX);

endmodule

// File: rtl/fp_wb_arbiter.sv
// Arbitrates FP intermediate-writeback sources into one registered output
// slot: longest-latency unit first, with an age override against starvation.
module fp_wb_arbiter
  import fpu_types::*;
#(
  parameter int NUM_SOURCES = 3,
  parameter int MAX_WAIT    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SOURCES-1:0]         src_done,
  input  fp_wb_payload_t                 src_payload [NUM_SOURCES],
  output logic [NUM_SOURCES-1:0]         src_ack,
  output logic                           out_done,
  output fp_wb_payload_t                 out_payload,
  output logic [$clog2(NUM_SOURCES)-1:0] out_src,
  input  logic                           out_ack
);

  localparam int SRC_W  = $clog2(NUM_SOURCES);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic                               capture_en;
  logic                               capture;
  logic [NUM_SOURCES-1:0]             starved;
  logic [NUM_SOURCES-1:0][WAIT_W-1:0] wait_cnt;
  logic [NUM_SOURCES-1:0]             grant;

  logic             starve_hit;
  logic [SRC_W-1:0] starve_idx;
  logic             high_hit;
  logic [SRC_W-1:0] high_idx;
  logic             sel_valid;
  logic [SRC_W-1:0] sel_idx;

  logic             out_done_q,    out_done_d;
  logic [SRC_W-1:0] out_src_q,     out_src_d;
  fp_wb_payload_t   out_payload_q, out_payload_d;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_age
    fp_wb_age_counter #(
      .MAX_WAIT (MAX_WAIT)
    ) u_age (
      .clk     (clk),
      .rst     (rst),
      .req     (src_done[g]),
      .ack     (src_ack[g]),
      .count   (wait_cnt[g]),
      .starved (starved[g])
    );
  end

  assign capture_en = ~out_done_q | out_ack;

  // Starved sources win lowest-index first; otherwise the slowest unit wins.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (src_done[i] && starved[i]) begin
        starve_hit = 1'b1;
        starve_idx = SRC_W'(i);
      end
    end

    high_hit = 1'b0;
    high_idx = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_done[i]) begin
        high_hit = 1'b1;
        high_idx = SRC_W'(i);
      end
    end

    sel_valid = starve_hit | high_hit;
    sel_idx   = starve_hit ? starve_idx : high_idx;

    for (int i = 0; i < NUM_SOURCES; i++) begin
      grant[i] = sel_valid && (sel_idx == SRC_W'(i));
    end
  end

  // Reset gates the acknowledge so no source believes it was captured.
  assign src_ack = {NUM_SOURCES{capture_en & ~rst}} & grant;
  assign capture = |src_ack;

  always_comb begin
    out_done_d    = out_done_q;
    out_src_d     = out_src_q;
    out_payload_d = out_payload_q;
    if (capture) begin
      out_done_d    = 1'b1;
      out_src_d     = sel_idx;
      out_payload_d = src_payload[sel_idx];
    end else if (out_ack) begin
      out_done_d    = 1'b0;
    end
  end

  // NOTE: the payload is a single pipeline register, not a storage array, so
  // clearing it on reset is cheap and keeps out_payload deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_done_q    <= 1'b0;
      out_src_q     <= '0;
      out_payload_q <= '0;
    end else begin
      out_done_q    <= out_done_d;
      out_src_q     <= out_src_d;
      out_payload_q <= out_payload_d;
    end
  end

  assign out_done    = out_done_q;
  assign out_src     = out_src_q;
  assign out_payload = out_payload_q;

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SOURCES, default 3, the number of FP intermediate-writeback requesters; index NUM_SOURCES-1 is the longest-latency unit.
REQ-002 SHALL have parameter MAX_WAIT, default 8, the starvation threshold in cycles.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port src_done, input, NUM_SOURCES, per-source result-ready, held until acked.
REQ-006 SHALL have port src_payload, input, NUM_SOURCES x fp_wb_payload_t, per-source intermediate result (id, rd, fflags, rm, grs, clz, shift and exponent fields).
REQ-007 SHALL have port src_ack, output, NUM_SOURCES, one-hot capture acknowledge.
REQ-008 SHALL have port out_done, output, 1, registered result valid.
REQ-009 SHALL have port out_payload, output, fp_wb_payload_t, registered result.
REQ-010 SHALL have port out_src, output, clog2(NUM_SOURCES), index of the source held in the output register.
REQ-011 SHALL have port out_ack, input, 1, downstream consumed the result.

Function
REQ-012 SHALL compute capture_en = ~out_done | out_ack, combinationally.
REQ-013 SHALL select the lowest-index requesting source whose wait count equals MAX_WAIT, if one exists; otherwise the highest-index requesting source.
REQ-014 SHALL drive src_ack[i] = capture_en & grant[i] combinationally, with at most one bit set per cycle.
REQ-015 SHALL, on a capture edge, load out_payload and out_src from the granted source and set out_done to 1.
REQ-016 SHALL clear out_done on out_ack when no source is captured in the same cycle.
REQ-017 SHALL keep out_done at 1 and load the new payload when out_ack and a capture occur in the same cycle, giving one result per cycle throughput.
REQ-018 SHALL hold out_payload and out_src stable while out_done=1 and out_ack=0.
REQ-019 SHALL have a latency of exactly 1 cycle from src_ack to the corresponding out_done.
REQ-020 SHALL increment wait[i], saturating at MAX_WAIT, each cycle src_done[i]=1 and src_ack[i]=0.
REQ-021 SHALL clear wait[i] when src_ack[i]=1 or src_done[i]=0.
REQ-022 SHALL drive src_ack all-zero when no source is requesting or capture_en=0; out_done and wait counters then behave as in REQ-016 and REQ-020.
REQ-023 SHALL ignore out_ack while out_done=0.
REQ-024 SHALL pass the payload unmodified; no sticky collapse or rounding occurs here.

Reset
REQ-025 SHALL, on rst assertion (asynchronous, active-high), clear out_done, out_src and all wait counters to 0.
REQ-026 SHALL set out_payload to all-zero on reset.
REQ-027 SHALL hold src_ack at 0 while rst=1.
REQ-028 SHALL discard a result already captured when reset is asserted mid-operation; uncaptured sources keep src_done and are re-arbitrated after reset.

Structure
REQ-029 SHALL define fp_wb_payload_t in fpu_types, shared with all FP writeback producers.
REQ-030 SHALL take GRS_WIDTH and the exponent widths from fpu_types, not redefine them locally.
REQ-031 SHALL implement each wait counter in one sub-module, fp_wb_age_counter, instantiated NUM_SOURCES times.
REQ-032 SHALL keep the grant logic inline.

Verification (NUM_SOURCES=3, MAX_WAIT=4)
REQ-033 SHALL cover: src_done=3'b011, out_ack tied 1 -> cycle0 src_ack=3'b010; cycle1 out_src=1 and src_ack=3'b001; cycle2 out_src=0.
REQ-034 SHALL cover: src_done[2] held 1 continuously, src_done[0]=1 -> src_ack[0] asserts on the cycle wait[0] reaches 4, overriding source 2.
REQ-035 SHALL cover: out_ack=0 for 5 cycles with src_done=3'b100 -> one capture only, out_payload stable, src_ack=0 for cycles 1-5.
REQ-036 SHALL cover: out_done=1 with out_ack=1 and src_done=3'b001 in the same cycle -> out_done remains 1 with the source-0 payload the next cycle.
REQ-037 SHALL cover: rst pulsed mid-stream while out_done=1 -> out_done=0 immediately (asynchronous), wait counters=0, held sources are granted again after release.
